mm_operand_feeder: RTL and testbench

MM_OPERAND_FEEDER -- requirements
Module: mm_operand_feeder

---
 rtl/mm_operand_feeder.sv | 81 ++++++++
 tb/tb_mm_operand_feeder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mm_operand_feeder.sv
// mm_operand_feeder: collects one vector and M matrix rows, issues them to the
// dot-product engine, then holds the engine result until downstream takes it.
module mm_operand_feeder #(
    parameter int M  = 16,
    parameter int N  = 16,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DW*N-1:0]     in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DW*N*M-1:0]   matrix_input,
    output logic [DW*N-1:0]     vector_input,
    output logic                input_valid,
    input  logic [DW*N-1:0]     vector_output,
    input  logic                add_valid,
    output logic [DW*N-1:0]     res_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                err,
    output logic [15:0]         op_count
);
    localparam int W  = DW * N;
    localparam int RW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [2:0] {LOAD_VEC, LOAD_ROW, ISSUE, WAIT, OUT} state_t;

    state_t          r_state, w_next;
    logic [RW-1:0]   r_row_cnt;
    logic            w_xfer;
    logic            w_last;

    assign in_ready    = (r_state == LOAD_VEC) || (r_state == LOAD_ROW);
    assign input_valid = r_state == ISSUE;
    assign res_valid   = r_state == OUT;
    assign w_xfer      = in_valid && in_ready;
    assign w_last      = r_row_cnt == RW'(M - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= LOAD_VEC;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LOAD_VEC: w_next = w_xfer ? LOAD_ROW : LOAD_VEC;
            LOAD_ROW: w_next = (w_xfer && w_last) ? ISSUE : LOAD_ROW;
            ISSUE:    w_next = WAIT;
            WAIT:     w_next = add_valid ? OUT : WAIT;
            OUT:      w_next = res_ready ? LOAD_VEC : OUT;
            default:  w_next = LOAD_VEC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_cnt    <= '0;
            matrix_input <= '0;
            vector_input <= '0;
            res_data     <= '0;
            err          <= 1'b0;
            op_count     <= '0;
        end else begin
            if (r_state == LOAD_VEC && w_xfer) begin
                vector_input <= in_data;
                r_row_cnt    <= '0;
            end
            if (r_state == LOAD_ROW && w_xfer) begin
                for (int i = 0; i < M; i++)
                    if (r_row_cnt == RW'(i)) matrix_input[i*W +: W] <= in_data;
                r_row_cnt <= w_last ? '0 : r_row_cnt + RW'(1);
            end
            if (r_state == WAIT && add_valid) res_data <= vector_output;
            // a result strobe outside WAIT is a protocol violation; data is dropped
            if (r_state != WAIT && add_valid) err <= 1'b1;
            if (r_state == OUT && res_ready) op_count <= op_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_mm_operand_feeder.sv
// tb_mm_operand_feeder: randomized operations against a queue-free operation
// model (expected vector/rows/result/count/err kept as plain variables).
module tb_mm_operand_feeder;
    localparam int M  = 16;
    localparam int N  = 16;
    localparam int DW = 32;
    localparam int W  = DW * N;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [W-1:0]     in_data;
    logic             in_valid;
    logic             in_ready;
    logic [W*M-1:0]   matrix_input;
    logic [W-1:0]     vector_input;
    logic             input_valid;
    logic [W-1:0]     vector_output;
    logic             add_valid;
    logic [W-1:0]     res_data;
    logic             res_valid;
    logic             res_ready;
    logic             err;
    logic [15:0]      op_count;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_iv   = 0;
    int   exp_iv = 0;
    int   exp_op = 0;
    bit   exp_err = 1'b0;
    bit   tie = 1'b0;
    logic [W-1:0] vec;
    logic [W-1:0] rows [M];

    always #5 clk = ~clk;

    mm_operand_feeder #(.M(M), .N(N), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .matrix_input(matrix_input), .vector_input(vector_input),
        .input_valid(input_valid), .vector_output(vector_output), .add_valid(add_valid),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .err(err), .op_count(op_count)
    );

    always @(negedge clk) if (input_valid === 1'b1) n_iv <= n_iv + 1;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic fill_rand();
        vec = rnd();
        for (int r = 0; r < M; r++) rows[r] = rnd();
    endtask

    // called on a negedge; returns on the negedge after the accepting edge
    task automatic send(input logic [W-1:0] d);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t == 50) chk("in_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_op(input int gap, input bit spur, input int hold, input int dly, input bit rst_wait);
        logic [W-1:0] x;
        x = rnd();
        send(vec);
        for (int r = 0; r < M; r++) begin
            if (gap != 0) @(negedge clk);
            if (spur && r == 5) begin
                add_valid = 1'b1;
                vector_output = rnd();
                @(negedge clk);
                add_valid = 1'b0;
                exp_err = 1'b1;
                chk("spur_err", err, 1);
                chk("spur_res_valid", res_valid, 0);
            end
            send(rows[r]);
        end
        exp_iv++;
        chk("iv_latency", input_valid, 1);
        chk("in_ready_issue", in_ready, 0);
        @(negedge clk);
        chk("iv_one_cycle", input_valid, 0);
        for (int r = 0; r < M; r++) chk($sformatf("row%0d", r), matrix_input[r*W +: W], rows[r]);
        chk("vector", vector_input, vec);
        if (rst_wait) begin
            #2 rst_n = 1'b0;
            #1;
            exp_op = 0;
            exp_err = 1'b0;
            chk("arst_mat", W'(|matrix_input), 0);
            chk("arst_vec", vector_input, 0);
            chk("arst_res", res_data, 0);
            chk("arst_iv", input_valid, 0);
            chk("arst_rv", res_valid, 0);
            chk("arst_err", err, 0);
            chk("arst_cnt", op_count, 0);
            @(negedge clk);
            rst_n = 1'b1;
            chk("arst_in_ready", in_ready, 1);
            return;
        end
        repeat (dly - 1) begin
            chk("wait_in_ready", in_ready, 0);
            @(negedge clk);
        end
        add_valid = 1'b1;
        vector_output = x;
        @(negedge clk);
        add_valid = 1'b0;
        vector_output = rnd();
        chk("res_valid", res_valid, 1);
        chk("res_data", res_data, x);
        chk("out_in_ready", in_ready, 0);
        repeat (hold) begin
            res_ready = 1'b0;
            in_valid = 1'b1;
            in_data = rnd();
            @(negedge clk);
            chk("bp_res_valid", res_valid, 1);
            chk("bp_res_data", res_data, x);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_vector", vector_input, vec);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = tie;
        exp_op = (exp_op + 1) % 65536;
        chk("op_count", op_count, exp_op);
        chk("post_in_ready", in_ready, 1);
        chk("post_res_valid", res_valid, 0);
        chk("err", err, exp_err);
        chk("iv_pulses", n_iv, exp_iv);
        chk("vector_hold", vector_input, vec);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        add_valid = 1'b0;
        vector_output = '0;
        res_ready = 1'b0;
        #3;
        chk("rst_mat", W'(|matrix_input), 0);
        chk("rst_vec", vector_input, 0);
        chk("rst_res", res_data, 0);
        chk("rst_iv", input_valid, 0);
        chk("rst_rv", res_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", op_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rel_in_ready", in_ready, 1);
        vec = '1;
        for (int r = 0; r < M; r++)
            for (int e = 0; e < N; e++) rows[r][e*DW +: DW] = DW'(r);
        run_op(0, 1'b0, 10, 3, 1'b0);
        fill_rand();
        run_op(1, 1'b0, 2, $urandom_range(1, 5), 1'b0);
        fill_rand();
        run_op(0, 1'b1, 0, 2, 1'b0);
        fill_rand();
        run_op(0, 1'b0, 0, 2, 1'b1);
        fill_rand();
        run_op(0, 1'b0, 1, 3, 1'b0);
        tie = 1'b1;
        res_ready = 1'b1;
        repeat (3) begin
            fill_rand();
            run_op(0, 1'b0, 0, $urandom_range(1, 4), 1'b0);
        end
        tie = 1'b0;
        res_ready = 1'b0;
        repeat (4) begin
            fill_rand();
            run_op($urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   $urandom_range(1, 6), 1'b0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
